// File: rtl/mdu_unit.sv
// ============================================================================
// Module   : mdu_unit
// Brief    : E-stage multiply/divide unit holding HI/LO. Multi-cycle
//            mult/multu/div/divu and single-cycle mthi/mtlo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        abs_a, abs_b, div_b, uq, ur, sq, sr;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    assign abs_a = A[31] ? (~A + 32'd1) : A;
    assign abs_b = B[31] ? (~B + 32'd1) : B;
    assign div_b = (B == 32'd0) ? 32'd1 : B;
    assign uq    = (MDU_op == OP_DIV) ? abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b) : A / div_b;
    assign ur    = (MDU_op == OP_DIV) ? abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b) : A % div_b;
    assign sq    = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
    assign sr    = A[31] ? (~ur + 32'd1) : ur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (MDU_op)
                        OP_MULT, OP_MULTU: begin
                            {sh_hi_d, sh_lo_d} = (MDU_op == OP_MULT) ? prod_s : prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero commits the current HI/LO back unchanged
                            if (B == 32'd0) begin
                                sh_hi_d = hi_q;
                                sh_lo_d = lo_q;
                            end else if (MDU_op == OP_DIV) begin
                                sh_hi_d = sr;
                                sh_lo_d = sq;
                            end else begin
                                sh_hi_d = ur;
                                sh_lo_d = uq;
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    hi_d    = sh_hi_q;
                    lo_d    = sh_lo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// Module   : tb_mdu_unit
// Brief    : Scoreboard bench for mdu_unit; expected commits queued at issue,
//            checked by a monitor when busy falls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  MDU_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic        prev_busy = 1'b0;
    int          run_len   = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .MDU_op(MDU_op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: holds HI/LO steady during busy, compares commit when busy falls
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_busy = 1'b0;
            run_len   = 0;
        end else begin
            if (busy) begin
                run_len++;
                check("hold_hi", HI, m_hi);
                check("hold_lo", LO, m_lo);
            end else if (prev_busy) begin
                if (sbq.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("commit_hi", HI, e.hi);
                    check("commit_lo", LO, e.lo);
                    check("busy_len", run_len, e.len);
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; MDU_op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MDU_op = 3'd0;
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int len);
        exp_t e;
        e.hi = hi; e.lo = lo; e.len = len;
        sbq.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; MDU_op = 3'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset_n = 1'b1;

        // MULT -2 * 3
        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // DIVU 17 / 5
        push(32'd2, 32'd3, 10);
        issue(3'd4, 32'd17, 32'd5);
        wait_idle();

        // DIV -7 / 2, then divide by zero keeps HI/LO
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd3, 32'd100, 32'd0);
        wait_idle();

        // MTHI while busy is ignored; MTHI/MTLO afterwards take effect at once
        push(32'd0, 32'd6, 5);
        issue(3'd1, 32'd2, 32'd3);
        issue(3'd5, 32'h0000_1234, 32'd0);
        wait_idle();
        issue(3'd5, 32'h0000_1234, 32'd0);
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'h0000_1234;
        issue(3'd6, 32'h0000_ABCD, 32'd0);
        check("mtlo_lo", LO, 32'h0000_ABCD);
        check("mtlo_hi", HI, 32'h0000_1234);
        m_lo = 32'h0000_ABCD;

        // MULTU max*max with DIVU held on start for four busy cycles
        push(32'hFFFF_FFFE, 32'h0000_0001, 5);
        @(posedge clk); #1;
        start = 1'b1; MDU_op = 3'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        MDU_op = 3'd4; A = 32'd9; B = 32'd2;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0; MDU_op = 3'd0;
        wait_idle();

        // Signed overflow: 0x80000000 / -1
        push(32'd0, 32'h8000_0000, 10);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // Reserved and NOP ops do nothing
        issue(3'd7, 32'h5555_5555, 32'd1);
        issue(3'd0, 32'h5555_5555, 32'd1);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", HI, 32'd0);
        check("nop_lo", LO, 32'h8000_0000);

        // Async reset in the middle of a DIV aborts without commit
        issue(3'd3, 32'd50, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        @(negedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
